// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the serial add/subtract sequencer.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell, time-shared by the serial sequencer.
module serial_add_ctrl_fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one result bit per cycle, LSB first.
// Optional out_zero flag is enabled with `define SERIAL_ADD_ZERO_FLAG_EN.
module serial_add_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             busy,
  output state_e           dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; flush suppresses either transfer in the same cycle.

  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q;
  logic [WIDTH-1:0] sh_b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q;
  logic             ovf_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic             nz_q;
  logic             zero_q;
`endif

  logic fa_sum;
  logic fa_cout;

  serial_add_ctrl_fulladder u_fa (
    .a_i    (sh_a_q[0]),
    .b_i    (sh_b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      nz_q    <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
            sh_a_q  <= in_a;
            sh_b_q  <= (in_sub == OP_ADD) ? in_b : ~in_b;
            carry_q <= (in_sub == OP_SUB);
            cnt_q   <= '0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            nz_q    <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sh_a_q  <= sh_a_q >> 1;
          sh_b_q  <= sh_b_q >> 1;
          res_q   <= {fa_sum, res_q[WIDTH-1:1]};
          carry_q <= fa_cout;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
          nz_q    <= nz_q | fa_sum;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            zero_q  <= ~(nz_q | fa_sum);
`endif
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_result   = res_q;
  assign out_carry    = cout_q;
  assign out_overflow = ovf_q;
  assign dbg_state_o  = state_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  assign out_zero     = zero_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl at WIDTH=32.
module tb_serial_add_ctrl;
  import serial_alu_pkg::*;

  localparam int W = 32;
  localparam int LAT_EXP = W + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_overflow;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic         out_zero;
`endif
  logic         busy;
  state_e       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sub       (in_sub),
    .in_a         (in_a),
    .in_b         (in_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    .out_zero     (out_zero),
`endif
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present an op just after an edge, hold for the handshake edge,
  // then scramble the operand bus so late changes would corrupt a bad DUT.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
  endtask

  // Edges counted from the handshake edge (=1) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", out_result); end
    total++; if (out_carry !== 1'b0 || out_overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got c=%b v=%b exp c=0 v=0", out_carry, out_overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", out_zero); end
`endif
  endtask

  // One op with out_ready=1; checks latency, result and flags.
  task automatic test_arith(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] exp_r, input logic exp_c,
                            input logic exp_v);
    int lat;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", name, in_ready); end
    start_op(a, b, sub);
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s_run got busy=%b in_ready=%b exp 1/0", name, busy, in_ready); end
    wait_done(lat);
    total++; if (lat !== LAT_EXP) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, LAT_EXP); end
    total++; if (out_result !== exp_r) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, out_result, exp_r); end
    total++; if (out_carry !== exp_c) begin bad++; $display("FAIL %s_carry got=%b exp=%b", name, out_carry, exp_c); end
    total++; if (out_overflow !== exp_v) begin bad++; $display("FAIL %s_ovf got=%b exp=%b", name, out_overflow, exp_v); end
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    total++; if (out_zero !== (exp_r == '0)) begin
      bad++; $display("FAIL %s_zero got=%b exp=%b", name, out_zero, (exp_r == '0)); end
`endif
    @(posedge clk); #1;
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL %s_accept got=%0d exp=%0d", name, dbg_state, IDLE); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] exp_r;
    logic [W-1:0] held;
    exp_q.push_back(32'h0000_0064);   // 100 + 0 held in DONE
    exp_q.push_back(32'h0000_0003);   // 10 - 7 accepted right after
    out_ready = 1'b0;
    start_op(32'd100, 32'd0, OP_ADD);
    wait_done(lat);
    total++; if (lat !== LAT_EXP) begin bad++; $display("FAIL hold_latency got=%0d exp=%0d", lat, LAT_EXP); end
    exp_r = exp_q.pop_front();
    held = out_result;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_result !== exp_r || in_ready !== 1'b0 || out_result !== held) begin
        bad++; $display("FAIL hold_cycle%0d got v=%b r=%h rdy=%b exp v=1 r=%h rdy=0", i, out_valid, out_result, in_ready, exp_r);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_release got rdy=%b v=%b exp 1/0", in_ready, out_valid); end
    start_op(32'd10, 32'd7, OP_SUB);
    total++; if (dbg_state !== RUN) begin bad++; $display("FAIL b2b_accept got=%0d exp=%0d", dbg_state, RUN); end
    wait_done(lat);
    exp_r = exp_q.pop_front();
    total++; if (out_result !== exp_r || out_carry !== 1'b1) begin
      bad++; $display("FAIL b2b_result got=%h c=%b exp=%h c=1", out_result, out_carry, exp_r); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int seen = 0;
    out_ready = 1'b1;
    start_op(32'h1234_5678, 32'h1111_1111, OP_ADD);
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    rst_n = 1'b0; #1;
    total++; if (dbg_state !== IDLE || busy !== 1'b0 || out_result !== '0) begin
      bad++; $display("FAIL rst_mid got st=%0d busy=%b r=%h exp IDLE/0/0", dbg_state, busy, out_result); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(32'h0F0F_0F0F, 32'h0101_0101, OP_SUB);
    for (int i = 0; i < 19; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (dbg_state !== IDLE || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_run got st=%0d rdy=%b exp IDLE/1", dbg_state, in_ready); end
    // Flush in IDLE beats a simultaneous request.
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_sub = OP_ADD; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL flush_idle got=%0d exp=%0d", dbg_state, IDLE); end
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
    test_arith("post_abort", 32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_arith("add_5_7",    32'd5,          32'd7, OP_ADD, 32'h0000_000C, 1'b0, 1'b0);
    test_arith("sub_0_1",    32'd0,          32'd1, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    test_arith("sub_9_9",    32'd9,          32'd9, OP_SUB, 32'h0000_0000, 1'b1, 1'b0);
    test_arith("add_ovf",    32'h7FFF_FFFF,  32'd1, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
    test_arith("add_wrap",   32'hFFFF_FFFF,  32'd1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0);
    test_arith("sub_ovf",    32'h8000_0000,  32'd1, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
